// File: rtl/mouse_packet_pacer_if.sv
// Packet bus between the HPS PS/2 mouse source and the mouse port consumers,
// carrying the paced output and the FIFO status back to the driver.
interface mouse_packet_pacer_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [24:0]   ps2_mouse_in;
  logic          hold;
  logic          clr_overflow;
  logic [24:0]   ps2_mouse_out;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output ps2_mouse_in, hold, clr_overflow,
    input  ps2_mouse_out, fifo_level, overflow
  );

  modport slave (
    input  ps2_mouse_in, hold, clr_overflow,
    output ps2_mouse_out, fifo_level, overflow
  );
endinterface

// File: rtl/mouse_packet_pacer.sv
// Buffers toggle-framed PS/2 mouse packets and re-emits them at most once per PACE_CYCLES.
// Define MOUSE_PACER_COALESCE_EN to merge packets arriving at a full FIFO into the tail entry.
module mouse_packet_pacer #(
  parameter int DEPTH       = 4,
  parameter int PACE_CYCLES = 4096
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  mouse_packet_pacer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PACE_CYCLES);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PACE_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(DEPTH);

  typedef enum logic {ST_WAIT, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic [24:0]   out_q;
  logic          primed_q, old_toggle_q, overflow_q;
  logic          new_pkt, full, emit, push, ovf_set;

  assign new_pkt = primed_q && (bus.ps2_mouse_in[24] != old_toggle_q);
  assign full    = (level_q == LVL_FULL);
  assign push    = new_pkt && (!full || emit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_READY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_READY: begin
        if ((level_q != '0) && !bus.hold) begin
          emit    = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_RELOAD;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= CNT_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MOUSE_PACER_COALESCE_EN
  logic [AW-1:0] tail_idx;
  logic          merge, sat_x, sat_y;
  logic [9:0]    sum_x, sum_y;
  logic [8:0]    res_x, res_y;
  logic [23:0]   merged;

  // Axes are 9-bit signed {sign, byte}; a 10-bit sum exposes 9-bit overflow as sum[9] != sum[8].
  assign tail_idx = wr_q - AW'(1);
  assign merge    = new_pkt && full && !emit;
  assign sum_x    = {{2{mem_q[tail_idx][4]}}, mem_q[tail_idx][15:8]}
                  + {{2{bus.ps2_mouse_in[4]}}, bus.ps2_mouse_in[15:8]};
  assign sum_y    = {{2{mem_q[tail_idx][5]}}, mem_q[tail_idx][23:16]}
                  + {{2{bus.ps2_mouse_in[5]}}, bus.ps2_mouse_in[23:16]};
  assign sat_x    = sum_x[9] != sum_x[8];
  assign sat_y    = sum_y[9] != sum_y[8];
  assign res_x    = sat_x ? (sum_x[9] ? 9'h100 : 9'h0FF) : sum_x[8:0];
  assign res_y    = sat_y ? (sum_y[9] ? 9'h100 : 9'h0FF) : sum_y[8:0];
  assign merged   = {res_y[7:0], res_x[7:0],
                     mem_q[tail_idx][7] | bus.ps2_mouse_in[7],
                     mem_q[tail_idx][6] | bus.ps2_mouse_in[6],
                     res_y[8], res_x[8], 1'b1, bus.ps2_mouse_in[2:0]};
  assign ovf_set  = merge && (sat_x || sat_y);
`else
  assign ovf_set  = new_pkt && full && !emit;
`endif

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_q] <= bus.ps2_mouse_in[23:0];
`ifdef MOUSE_PACER_COALESCE_EN
    else if (merge) mem_q[tail_idx] <= merged;
`endif
  end

  // When full, a same-clock push lands in the slot being popped; the pop reads the old value.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      primed_q     <= 1'b0;
      old_toggle_q <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      out_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      primed_q     <= 1'b1;
      old_toggle_q <= bus.ps2_mouse_in[24];
      if (push) wr_q <= wr_q + AW'(1);
      if (emit) begin
        rd_q  <= rd_q + AW'(1);
        out_q <= {~out_q[24], mem_q[rd_q]};
      end
      case ({push, emit})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
      if (ovf_set)               overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
    end
  end

  assign bus.ps2_mouse_out = out_q;
  assign bus.fifo_level    = level_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_mouse_packet_pacer.sv
// Scoreboard bench for mouse_packet_pacer: a queue-based reference model predicts emissions,
// FIFO level and overflow; a negedge monitor compares whenever the output packet changes.
module tb_mouse_packet_pacer;
  localparam int DEPTH = 4;
  localparam int PACE  = 16;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  mouse_packet_pacer_if #(.DEPTH(DEPTH)) bus ();

  mouse_packet_pacer #(.DEPTH(DEPTH), .PACE_CYCLES(PACE)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic [23:0] m_fifo[$];
  int          m_edge, m_ready_edge;
  logic        m_prev_tog, m_ovf;
  logic [24:0] m_out;
  bit          m_emit, m_full, m_newp, m_sat;
  logic [23:0] m_head;

  logic [24:0] prev_out;
  logic [23:0] last_val;
  int          cyc = 0;
  int          last_emit_cyc = -1;
  int          em_count = 0;
  logic        tog;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] data);
    @(negedge clk_sys);
    tog = ~tog;
    bus.ps2_mouse_in = {tog, data};
  endtask

  function automatic int axisValue(input logic s, input logic [7:0] v);
    return s ? int'(v) - 256 : int'(v);
  endfunction

`ifdef MOUSE_PACER_COALESCE_EN
  function automatic logic [23:0] coalesce(input logic [23:0] t, input logic [23:0] n, output bit sat);
    int x, y;
    logic [8:0] rx, ry;
    x = axisValue(t[4], t[15:8]) + axisValue(n[4], n[15:8]);
    y = axisValue(t[5], t[23:16]) + axisValue(n[5], n[23:16]);
    sat = 1'b0;
    if (x > 255)  begin x = 255;  sat = 1'b1; end
    if (x < -256) begin x = -256; sat = 1'b1; end
    if (y > 255)  begin y = 255;  sat = 1'b1; end
    if (y < -256) begin y = -256; sat = 1'b1; end
    rx = 9'(x);
    ry = 9'(y);
    return {ry[7:0], rx[7:0], t[7] | n[7], t[6] | n[6], ry[8], rx[8], 1'b1, n[2:0]};
  endfunction
`endif

  // Reference model: emission allowed once PACE+1 edges have passed since the last one.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_edge       = 0;
      m_ready_edge = PACE + 1;
      m_prev_tog   = 1'b0;
      m_ovf        = 1'b0;
      m_out        = '0;
    end else begin
      m_edge++;
      m_full     = (m_fifo.size() == DEPTH);
      m_emit     = (m_edge >= m_ready_edge) && (m_fifo.size() > 0) && !bus.hold;
      m_newp     = (m_edge >= 2) && (bus.ps2_mouse_in[24] != m_prev_tog);
      m_prev_tog = bus.ps2_mouse_in[24];
      m_sat      = 1'b0;
      if (m_emit) begin
        m_head = m_fifo.pop_front();
        m_out  = {~m_out[24], m_head};
        exp_q.push_back(m_out);
        m_ready_edge = m_edge + PACE + 1;
      end
      if (m_newp) begin
        if (!m_full || m_emit) m_fifo.push_back(bus.ps2_mouse_in[23:0]);
        else begin
`ifdef MOUSE_PACER_COALESCE_EN
          m_fifo[m_fifo.size()-1] = coalesce(m_fifo[m_fifo.size()-1], bus.ps2_mouse_in[23:0], m_sat);
`else
          m_sat = 1'b1;
`endif
        end
      end
      if (m_sat) m_ovf = 1'b1;
      else if (bus.clr_overflow) m_ovf = 1'b0;
    end
  end

  // Monitor: every output change must match the next predicted packet.
  always @(negedge clk_sys) begin
    cyc++;
    if (!reset_n) begin
      prev_out      = '0;
      last_emit_cyc = -1;
    end else begin
      if (bus.ps2_mouse_out !== prev_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_emit: got 0x%0h expected no change from 0x%0h",
                   bus.ps2_mouse_out, prev_out);
        end else begin
          checkOutput("emit_packet", bus.ps2_mouse_out, exp_q.pop_front());
        end
        if (last_emit_cyc >= 0)
          checkOutput("emit_spacing", (cyc - last_emit_cyc) >= PACE, 1);
        prev_out      = bus.ps2_mouse_out;
        last_val      = bus.ps2_mouse_out[23:0];
        last_emit_cyc = cyc;
        em_count++;
      end
      checkOutput("fifo_level", bus.fifo_level, m_fifo.size());
      checkOutput("overflow", bus.overflow, m_ovf);
    end
  end

  int          base;
  logic [23:0] pk1;

  initial begin
    bus.ps2_mouse_in = 25'h1000000;
    bus.hold         = 1'b0;
    bus.clr_overflow = 1'b0;
    tog              = 1'b1;
    reset_n          = 1'b0;
    #23;
    checkOutput("reset_out", bus.ps2_mouse_out, 0);
    checkOutput("reset_level", bus.fifo_level, 0);
    checkOutput("reset_overflow", bus.overflow, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    repeat (PACE + 10) @(negedge clk_sys);
    checkOutput("no_capture_level", bus.fifo_level, 0);
    checkOutput("no_capture_out", bus.ps2_mouse_out, 0);

    applyStimulus(24'hFE0521);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    checkOutput("latency_out", bus.ps2_mouse_out, {1'b1, 24'hFE0521});
    checkOutput("latency_level", bus.fifo_level, 0);

    repeat (PACE + 5) @(negedge clk_sys);
    base = em_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(24'($urandom));
      repeat (3) @(negedge clk_sys);
    end
    repeat (8 * (PACE + 2)) @(negedge clk_sys);
    checkOutput("six_emits", em_count - base, 6);

    bus.hold = 1'b1;
    base = em_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(24'h006400);
      @(negedge clk_sys);
    end
    repeat (3) @(negedge clk_sys);
    checkOutput("fill_level", bus.fifo_level, 4);
    checkOutput("fill_overflow", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    @(negedge clk_sys);
    bus.clr_overflow = 1'b0;
    checkOutput("clr_overflow", bus.overflow, 0);
    bus.hold = 1'b0;
    repeat (6 * (PACE + 2)) @(negedge clk_sys);
    checkOutput("fill_emits", em_count - base, 4);
`ifdef MOUSE_PACER_COALESCE_EN
    checkOutput("tail_packet", last_val, 24'h00FF08);
`else
    checkOutput("tail_packet", last_val, 24'h006400);
`endif

    bus.hold = 1'b1;
    pk1 = 24'($urandom);
    applyStimulus(pk1);
    repeat (2) @(negedge clk_sys);
    applyStimulus(24'($urandom));
    repeat (100) @(negedge clk_sys);
    checkOutput("hold_stable", bus.ps2_mouse_out, m_out);
    checkOutput("hold_level", bus.fifo_level, 2);
    bus.hold = 1'b0;
    @(posedge clk_sys);
    #1;
    checkOutput("hold_release_emit", bus.ps2_mouse_out[23:0], pk1);
    repeat (2 * PACE + 10) @(negedge clk_sys);

    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(24'($urandom));
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_out", bus.ps2_mouse_out, 0);
    checkOutput("midreset_level", bus.fifo_level, 0);
    checkOutput("midreset_overflow", bus.overflow, 0);
    repeat (2) @(negedge clk_sys);
    reset_n  = 1'b1;
    bus.hold = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_sys);
      if ($urandom_range(0, 3) == 0) begin
        tog = ~tog;
        bus.ps2_mouse_in = {tog, 24'($urandom)};
      end
      if ($urandom_range(0, 15) == 0) bus.hold = ~bus.hold;
      bus.clr_overflow = ($urandom_range(0, 15) == 0);
    end
    bus.hold         = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat ((DEPTH + 2) * (PACE + 2)) @(negedge clk_sys);
    checkOutput("drain_pending", exp_q.size(), 0);
    checkOutput("drain_level", bus.fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
